// File: rtl/max7219_frame_serializer.sv
// Snapshots six BCD stopwatch digits and streams them as 16-bit MAX7219 register
// writes over SPI mode 0, after a one-time configuration burst following reset.
module max7219_frame_serializer #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ena,
    input  logic [2:0] min_X0,
    input  logic [3:0] min_0X,
    input  logic [2:0] sec_X0,
    input  logic [3:0] sec_0X,
    input  logic [3:0] ces_X0,
    input  logic [3:0] ces_0X,
    output logic       MOSI,
    output logic       CS,
    output logic       clk_SPI,
    output logic       busy
);

    typedef enum logic [1:0] {INIT, IDLE, SNAP, REFRESH} state_t;

    localparam int            DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    // Phases 0..32 are the CS-low half-bit slots (even = SCLK low); 33 is the CS-high gap.
    localparam logic [5:0]    TRAIL    = 6'd32;
    localparam logic [5:0]    GAP      = 6'd33;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [5:0]    phase, phase_nxt;
    logic [2:0]    frame, frame_nxt;
    logic          tick;
    logic          active;
    logic [15:0]   word;

    logic [3:0] sh_ces_0X, sh_ces_X0, sh_sec_0X, sh_min_0X;
    logic [2:0] sh_sec_X0, sh_min_X0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= INIT;
            div_cnt <= '0;
            phase   <= GAP;
            frame   <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            phase   <= phase_nxt;
            frame   <= frame_nxt;
        end
    end

    // NOTE: the shadow is a handful of flops, not a memory, so it gets a defined reset value.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sh_ces_0X <= '0;
            sh_ces_X0 <= '0;
            sh_sec_0X <= '0;
            sh_sec_X0 <= '0;
            sh_min_0X <= '0;
            sh_min_X0 <= '0;
        end else if (state == SNAP) begin
            sh_ces_0X <= ces_0X;
            sh_ces_X0 <= ces_X0;
            sh_sec_0X <= sec_0X;
            sh_sec_X0 <= sec_X0;
            sh_min_0X <= min_0X;
            sh_min_X0 <= min_X0;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path infers a latch.
    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        state_nxt = state;
        div_nxt   = '0;
        phase_nxt = phase;
        frame_nxt = frame;
        unique case (state)
            INIT: begin
                div_nxt = tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    if (phase == GAP) begin
                        phase_nxt = '0;
                    end else if (phase == TRAIL) begin
                        phase_nxt = GAP;
                        if (frame == 3'd4) begin
                            state_nxt = IDLE;
                            frame_nxt = '0;
                        end else begin
                            frame_nxt = frame + 3'd1;
                        end
                    end else begin
                        phase_nxt = phase + 6'd1;
                    end
                end
            end
            IDLE: begin
                if (ena) state_nxt = SNAP;
            end
            SNAP: begin
                state_nxt = REFRESH;
                phase_nxt = '0;
                frame_nxt = '0;
            end
            REFRESH: begin
                div_nxt = tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    if (phase == GAP) begin
                        if (frame == 3'd5) begin
                            // Skipping IDLE keeps back-to-back passes free of an extra idle cycle.
                            state_nxt = ena ? SNAP : IDLE;
                            frame_nxt = '0;
                        end else begin
                            frame_nxt = frame + 3'd1;
                            phase_nxt = '0;
                        end
                    end else begin
                        phase_nxt = phase + 6'd1;
                    end
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        word = '0;
        if (state == INIT) begin
            case (frame)
                3'd0:    word = 16'h0C01;
                3'd1:    word = 16'h09FF;
                3'd2:    word = 16'h0B05;
                3'd3:    word = 16'h0A08;
                default: word = 16'h0F00;
            endcase
        end else begin
            case (frame)
                3'd0:    word = {8'h01, 4'h0, sh_ces_0X};
                3'd1:    word = {8'h02, 4'h0, sh_ces_X0};
                3'd2:    word = {8'h03, 4'h8, sh_sec_0X};
                3'd3:    word = {8'h04, 5'h0, sh_sec_X0};
                3'd4:    word = {8'h05, 4'h8, sh_min_0X};
                default: word = {8'h06, 5'h0, sh_min_X0};
            endcase
        end
    end

    // Outputs decode straight from reset-cleared registers, so reset forces them idle at once.
    always_comb begin
        active  = ((state == INIT) || (state == REFRESH)) && (phase != GAP);
        CS      = !active;
        clk_SPI = active && phase[0];
        MOSI    = active && (phase < TRAIL) && word[4'd15 - phase[4:1]];
        busy    = (state != IDLE);
    end

endmodule

// File: tb/tb_max7219_frame_serializer.sv
// Self-checking bench: decodes the SPI stream of two instances (CLK_DIV 8 and 2)
// and compares frames and timing against a digit-level reference model.
module tb_max7219_frame_serializer;

    typedef struct packed {
        logic [2:0] mX0;
        logic [3:0] m0X;
        logic [2:0] sX0;
        logic [3:0] s0X;
        logic [3:0] cX0;
        logic [3:0] c0X;
    } digits_t;

    typedef struct packed {
        digits_t          d;
        logic [5:0][15:0] exp;
    } vec_t;

    logic    clk = 1'b0;
    logic    res_a, res_b, ena_a, ena_b;
    digits_t dig_a, dig_b;
    logic    mosi_a, cs_a, sclk_a, busy_a;
    logic    mosi_b, cs_b, sclk_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    max7219_frame_serializer #(.CLK_DIV(8)) dut_a (
        .clk(clk), .res(res_a), .ena(ena_a),
        .min_X0(dig_a.mX0), .min_0X(dig_a.m0X), .sec_X0(dig_a.sX0),
        .sec_0X(dig_a.s0X), .ces_X0(dig_a.cX0), .ces_0X(dig_a.c0X),
        .MOSI(mosi_a), .CS(cs_a), .clk_SPI(sclk_a), .busy(busy_a)
    );

    max7219_frame_serializer #(.CLK_DIV(2)) dut_b (
        .clk(clk), .res(res_b), .ena(ena_b),
        .min_X0(dig_b.mX0), .min_0X(dig_b.m0X), .sec_X0(dig_b.sX0),
        .sec_0X(dig_b.s0X), .ces_X0(dig_b.cX0), .ces_0X(dig_b.c0X),
        .MOSI(mosi_b), .CS(cs_b), .clk_SPI(sclk_b), .busy(busy_b)
    );

    logic [1:0] cs_w, sclk_w, mosi_w, busy_w;
    assign cs_w   = {cs_b, cs_a};
    assign sclk_w = {sclk_b, sclk_a};
    assign mosi_w = {mosi_b, mosi_a};
    assign busy_w = {busy_b, busy_a};

    // SPI decoder per instance: shifts MOSI on SCLK rises, logs whole 16-bit frames at CS rise.
    logic [1:0]  pcs = 2'b11;
    logic [1:0]  psclk = 2'b00;
    logic [15:0] sh [2];
    int          nb [2]       = '{0, 0};
    int          lrun [2]     = '{0, 0};
    int          hrun [2]     = '{0, 0};
    int          srun [2]     = '{0, 0};
    int          smin [2]     = '{1000, 1000};
    int          smax [2]     = '{0, 0};
    int          gap_last [2] = '{0, 0};
    int          fcnt [2]     = '{0, 0};
    logic [15:0] flog [2][256];
    int          lowlog [2][256];
    int          gaplog [2][256];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!cs_w[k]) begin
                if (pcs[k]) begin
                    gap_last[k] <= hrun[k];
                    lrun[k] <= 1;
                    nb[k]   <= 0;
                    sh[k]   <= '0;
                    srun[k] <= 1;
                end else begin
                    lrun[k] <= lrun[k] + 1;
                    if (sclk_w[k] != psclk[k]) begin
                        if (srun[k] < smin[k]) smin[k] <= srun[k];
                        if (srun[k] > smax[k]) smax[k] <= srun[k];
                        srun[k] <= 1;
                        if (sclk_w[k]) begin
                            sh[k] <= {sh[k][14:0], mosi_w[k]};
                            nb[k] <= nb[k] + 1;
                        end
                    end else begin
                        srun[k] <= srun[k] + 1;
                    end
                end
            end else begin
                if (!pcs[k]) begin
                    if (srun[k] < smin[k]) smin[k] <= srun[k];
                    if (srun[k] > smax[k]) smax[k] <= srun[k];
                    if (nb[k] == 16 && fcnt[k] < 256) begin
                        flog[k][fcnt[k]]   <= sh[k];
                        lowlog[k][fcnt[k]] <= lrun[k];
                        gaplog[k][fcnt[k]] <= gap_last[k];
                        fcnt[k] <= fcnt[k] + 1;
                    end
                    hrun[k] <= 1;
                end else begin
                    hrun[k] <= hrun[k] + 1;
                end
            end
            pcs[k]   <= cs_w[k];
            psclk[k] <= sclk_w[k];
        end
    end

    logic [15:0] init_seq [5] = '{16'h0C01, 16'h09FF, 16'h0B05, 16'h0A08, 16'h0F00};

    // Reference: register k+1 carries the k-th digit (units before tens), DP on seconds/minutes units.
    function automatic logic [15:0] ref_frame(input digits_t d, input int k);
        logic [3:0] vals [6];
        logic [7:0] data;
        vals = '{d.c0X, d.cX0, d.s0X, {1'b0, d.sX0}, d.m0X, {1'b0, d.mX0}};
        data = {4'h0, vals[k]} + ((k == 2 || k == 4) ? 8'd128 : 8'd0);
        return {8'(k + 1), data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_idle(input int k, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (busy_w[k] && cyc < limit);
        if (busy_w[k]) timeout("wait_idle");
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int limit);
        int cyc = 0;
        while (fcnt[0] < target && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (fcnt[0] < target) timeout("wait_frames");
    endtask

    task automatic wait_cs_low(input int limit);
        int cyc = 0;
        while (cs_a && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (cs_a) timeout("wait_cs_low");
    endtask

    // One pass on instance A: inputs d at SNAP, then scrambled to `late` once the pass is under way.
    task automatic run_pass(input digits_t d, input digits_t late, output int start, output int cyc);
        dig_a = d;
        start = fcnt[0];
        ena_a = 1'b1;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("snap_cs_high", 32'(cs_a), 32'd1);
            if (cyc == 2) check("ena_to_cs_fall", 32'(cs_a), 32'd0);
            if (cyc == 3) begin
                ena_a = 1'b0;
                dig_a = late;
            end
        end while (busy_a && cyc < 4000);
        if (busy_a) timeout("run_pass");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_pass(input int start, input digits_t d);
        check("pass_frame_count", 32'(fcnt[0]), 32'(start + 6));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("pass_frame%0d", i), 32'(flog[0][start + i]), 32'(ref_frame(d, i)));
        end
    endtask

    initial begin
        vec_t       vecs [4];
        digits_t    d, late, zero, d1234;
        logic [21:0] r;
        int         s, cyc, lows;

        vecs[0].d = '{mX0: 3'd1, m0X: 4'd2, sX0: 3'd3, s0X: 4'd4, cX0: 4'd5, c0X: 4'd6};
        vecs[0].exp = {16'h0601, 16'h0582, 16'h0403, 16'h0384, 16'h0205, 16'h0106};
        vecs[1].d = '{mX0: 3'd0, m0X: 4'd0, sX0: 3'd0, s0X: 4'd0, cX0: 4'd0, c0X: 4'd0};
        vecs[1].exp = {16'h0600, 16'h0580, 16'h0400, 16'h0380, 16'h0200, 16'h0100};
        vecs[2].d = '{mX0: 3'd5, m0X: 4'd9, sX0: 3'd5, s0X: 4'd9, cX0: 4'd9, c0X: 4'd9};
        vecs[2].exp = {16'h0605, 16'h0589, 16'h0405, 16'h0389, 16'h0209, 16'h0109};
        vecs[3].d = '{mX0: 3'd7, m0X: 4'd15, sX0: 3'd6, s0X: 4'd10, cX0: 4'd12, c0X: 4'd11};
        vecs[3].exp = {16'h0607, 16'h058F, 16'h0406, 16'h038A, 16'h020C, 16'h010B};
        d1234 = vecs[0].d;
        zero  = vecs[1].d;

        res_a = 1'b1; res_b = 1'b1; ena_a = 1'b0; ena_b = 1'b0;
        dig_a = d1234; dig_b = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs_a), 32'd1);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd1);

        // Init burst with ena low.
        #2 res_a = 1'b0;
        wait_idle(0, 3000, cyc);
        check("init_duration", 32'(cyc), 32'd1360);
        check("init_frame_count", 32'(fcnt[0]), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("init_frame%0d", i), 32'(flog[0][i]), 32'(init_seq[i]));
            check($sformatf("init_cs_low%0d", i), 32'(lowlog[0][i]), 32'd264);
            if (i > 0) check($sformatf("init_gap%0d", i), 32'(gaplog[0][i]), 32'd8);
        end
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!cs_a || busy_a) lows++;
        end
        check("idle_quiet", 32'(lows), 32'd0);
        check("idle_no_frames", 32'(fcnt[0]), 32'd5);

        // Table-driven passes.
        for (int i = 0; i < 4; i++) begin
            run_pass(vecs[i].d, vecs[i].d, s, cyc);
            check($sformatf("vec%0d_duration", i), 32'(cyc), 32'd1634);
            check($sformatf("vec%0d_count", i), 32'(fcnt[0]), 32'(s + 6));
            for (int j = 0; j < 6; j++)
                check($sformatf("vec%0d_frame%0d", i, j), 32'(flog[0][s + j]), 32'(vecs[i].exp[j]));
        end

        // Random digits, scrambled right after the snapshot.
        for (int i = 0; i < 4; i++) begin
            r = 22'($urandom);
            d = r;
            r = 22'($urandom);
            late = r;
            run_pass(d, late, s, cyc);
            check_pass(s, d);
        end
        check("sclk_phase_min", 32'(smin[0]), 32'd8);
        check("sclk_phase_max", 32'(smax[0]), 32'd8);

        // Back-to-back passes; digits zeroed during frame 0x0205 of the first.
        dig_a = d1234;
        s = fcnt[0];
        ena_a = 1'b1;
        wait_frames(s + 1, 2000);
        wait_cs_low(100);
        dig_a = zero;
        wait_frames(s + 7, 3000);
        ena_a = 1'b0;
        wait_idle(0, 3000, cyc);
        check("b2b_count", 32'(fcnt[0]), 32'(s + 12));
        for (int j = 0; j < 6; j++) begin
            check($sformatf("coh_old%0d", j), 32'(flog[0][s + j]), 32'(vecs[0].exp[j]));
            check($sformatf("coh_new%0d", j), 32'(flog[0][s + 6 + j]), 32'(vecs[1].exp[j]));
        end
        check("b2b_gap", 32'(gaplog[0][s + 6]), 32'd9);

        // Drop ena during frame 0x0384.
        dig_a = d1234;
        s = fcnt[0];
        ena_a = 1'b1;
        wait_frames(s + 2, 2000);
        wait_cs_low(100);
        ena_a = 1'b0;
        wait_idle(0, 3000, cyc);
        check_pass(s, d1234);
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!cs_a) lows++;
        end
        check("drop_cs_quiet", 32'(lows), 32'd0);
        check("drop_no_frames", 32'(fcnt[0]), 32'(s + 6));

        // Reset in the middle of bit 7 of frame 0x0384.
        s = fcnt[0];
        ena_a = 1'b1;
        wait_frames(s + 2, 2000);
        wait_cs_low(100);
        cyc = 0;
        while (nb[0] != 9 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (nb[0] != 9) timeout("wait_bit7");
        repeat (3) @(negedge clk);
        s = fcnt[0];
        #2 res_a = 1'b1;
        #1;
        check("async_rst_cs", 32'(cs_a), 32'd1);
        check("async_rst_sclk", 32'(sclk_a), 32'd0);
        check("async_rst_mosi", 32'(mosi_a), 32'd0);
        ena_a = 1'b0;
        repeat (3) @(negedge clk);
        #2 res_a = 1'b0;
        wait_idle(0, 3000, cyc);
        check("rerst_count", 32'(fcnt[0]), 32'(s + 5));
        for (int i = 0; i < 5; i++)
            check($sformatf("rerst_frame%0d", i), 32'(flog[0][s + i]), 32'(init_seq[i]));

        // Instance with CLK_DIV = 2.
        @(negedge clk);
        #2 res_b = 1'b0;
        wait_idle(1, 1000, cyc);
        check("d2_init_duration", 32'(cyc), 32'd340);
        check("d2_init_count", 32'(fcnt[1]), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("d2_init_frame%0d", i), 32'(flog[1][i]), 32'(init_seq[i]));
            check($sformatf("d2_cs_low%0d", i), 32'(lowlog[1][i]), 32'd66);
            if (i > 0) check($sformatf("d2_gap%0d", i), 32'(gaplog[1][i]), 32'd2);
        end
        r = 22'($urandom);
        d = r;
        dig_b = d;
        ena_b = 1'b1;
        repeat (3) @(negedge clk);
        ena_b = 1'b0;
        wait_idle(1, 1000, cyc);
        check("d2_pass_count", 32'(fcnt[1]), 32'd11);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("d2_frame%0d", j), 32'(flog[1][5 + j]), 32'(ref_frame(d, j)));
            check($sformatf("d2_pass_cs_low%0d", j), 32'(lowlog[1][5 + j]), 32'd66);
        end
        check("d2_sclk_phase_min", 32'(smin[1]), 32'd2);
        check("d2_sclk_phase_max", 32'(smax[1]), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
